// File: rtl/clks_alot_violation_ctrl.sv
// Multi-channel violation controller: leaky-bucket level per channel feeding a MONITOR/WARN/FAULT/HOLDOFF FSM with 4-phase clear.
// Latency: one cycle from a sampled violation to level/warn/fault/fault_event/sticky; any_fault_o is an OR of registered fault bits.
// Backpressure: none; every input is sampled every cycle. Optional sticky source latches are built when CLKS_ALOT_VIOLATION_STICKY_EN is defined.

package common_p;
    typedef struct packed {
        logic clk;
        logic rst;
    } clk_dom_s;
endpackage

module clks_alot_violation_ctrl #(
    parameter int CHANNELS = 4,
    parameter int SRCS     = 5,
    parameter int CNT_W    = 8,
    parameter int HOLD_W   = 16
) (
    input  common_p::clk_dom_s           sys_dom_i,
    input  logic                         enable_i,
    input  logic [CHANNELS*SRCS-1:0]     violations_i,
    input  logic [CHANNELS*SRCS-1:0]     src_mask_i,
    input  logic [CNT_W-1:0]             growth_rate_i,
    input  logic [CNT_W-1:0]             decay_rate_i,
    input  logic [CNT_W-1:0]             saturation_limit_i,
    input  logic [CNT_W-1:0]             trigger_limit_i,
    input  logic [CNT_W-1:0]             release_limit_i,
    input  logic [HOLD_W-1:0]            holdoff_cycles_i,
    input  logic [CHANNELS-1:0]          clear_req_i,
    output logic [CHANNELS-1:0]          clear_ack_o,
    output logic [CHANNELS*CNT_W-1:0]    level_o,
    output logic [CHANNELS-1:0]          warn_o,
    output logic [CHANNELS-1:0]          fault_o,
    output logic [CHANNELS-1:0]          fault_event_o,
    output logic                         any_fault_o,
    output logic [CHANNELS*SRCS-1:0]     sticky_src_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MONITOR = 3'd1,
        ST_WARN    = 3'd2,
        ST_FAULT   = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_e;

    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    logic clk;
    logic rst;

    assign clk = sys_dom_i.clk;
    assign rst = sys_dom_i.rst;

    // Per-channel registered state
    state_e            state_q [CHANNELS];
    logic [CNT_W-1:0]  level_q [CHANNELS];
    logic [HOLD_W-1:0] hold_q  [CHANNELS];

    // Next-state values
    state_e            state_d [CHANNELS];
    logic [CNT_W-1:0]  level_d [CHANNELS];
    logic [HOLD_W-1:0] hold_d  [CHANNELS];

    // Datapath helpers
    logic [CHANNELS-1:0] hit;
    logic [CNT_W:0]      sum_w   [CHANNELS];
    logic [CNT_W-1:0]    lvl_upd [CHANNELS];
    logic                trig_armed;

    // Registered outputs and their next values
    logic [CHANNELS-1:0] warn_q, fault_q, fevent_q, ack_q;
    logic [CHANNELS-1:0] warn_d, fault_d, fevent_d;

    // A zero trigger means "fault disabled"; a trigger above saturation can never be reached.
    assign trig_armed = (trigger_limit_i != '0) && (trigger_limit_i <= saturation_limit_i);

    // Masked per-channel hit and the saturating/non-wrapping bucket update, done one bit wider.
    always_comb begin
        hit = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            hit[c]   = |(violations_i[c*SRCS +: SRCS] & src_mask_i[c*SRCS +: SRCS]);
            sum_w[c] = {1'b0, level_q[c]} + {1'b0, growth_rate_i};
            if (hit[c]) begin
                if (sum_w[c] > {1'b0, saturation_limit_i}) begin
                    lvl_upd[c] = saturation_limit_i;
                end else begin
                    lvl_upd[c] = sum_w[c][CNT_W-1:0];
                end
            end else if (level_q[c] > decay_rate_i) begin
                lvl_upd[c] = level_q[c] - decay_rate_i;
            end else begin
                lvl_upd[c] = '0;
            end
        end
    end

    // Next-state logic: disable beats clear, clear beats any hit or trigger, then the per-state rules on the new level.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            state_d[c] = state_q[c];
            level_d[c] = lvl_upd[c];
            hold_d[c]  = hold_q[c];
            if (!enable_i) begin
                state_d[c] = ST_IDLE;
                level_d[c] = '0;
                hold_d[c]  = '0;
            end else if (clear_req_i[c]) begin
                state_d[c] = ST_MONITOR;
                level_d[c] = '0;
                hold_d[c]  = '0;
            end else begin
                case (state_q[c])
                    ST_IDLE: begin
                        // Leaving IDLE is a clean start: the level stays at zero for this edge.
                        state_d[c] = ST_MONITOR;
                        level_d[c] = '0;
                        hold_d[c]  = '0;
                    end
                    ST_MONITOR: begin
                        if (trig_armed && (lvl_upd[c] >= trigger_limit_i)) begin
                            state_d[c] = ST_FAULT;
                        end else if (lvl_upd[c] != '0) begin
                            state_d[c] = ST_WARN;
                        end
                    end
                    ST_WARN: begin
                        if (trig_armed && (lvl_upd[c] >= trigger_limit_i)) begin
                            state_d[c] = ST_FAULT;
                        end else if (lvl_upd[c] == '0) begin
                            state_d[c] = ST_MONITOR;
                        end
                    end
                    ST_FAULT: begin
                        if (lvl_upd[c] <= release_limit_i) begin
                            state_d[c] = ST_HOLDOFF;
                            hold_d[c]  = holdoff_cycles_i;
                        end
                    end
                    ST_HOLDOFF: begin
                        // The counter is loaded with N and the exit is taken on the cycle it holds 1 (or 0),
                        // so HOLDOFF lasts N cycles, and a zero load still leaves after one cycle.
                        if (hit[c]) begin
                            state_d[c] = ST_FAULT;
                        end else if ((hold_q[c] == '0) || (hold_q[c] == HOLD_ONE)) begin
                            state_d[c] = (lvl_upd[c] == '0) ? ST_MONITOR : ST_WARN;
                            hold_d[c]  = '0;
                        end else begin
                            hold_d[c]  = hold_q[c] - HOLD_ONE;
                        end
                    end
                    default: begin
                        state_d[c] = ST_IDLE;
                        level_d[c] = '0;
                        hold_d[c]  = '0;
                    end
                endcase
            end
        end
    end

    // Output decode from the next state, so the registered flags line up with the new level.
    always_comb begin
        warn_d   = '0;
        fault_d  = '0;
        fevent_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            warn_d[c]   = (state_d[c] == ST_WARN);
            fault_d[c]  = (state_d[c] == ST_FAULT) || (state_d[c] == ST_HOLDOFF);
            fevent_d[c] = (state_d[c] == ST_FAULT) && (state_q[c] != ST_FAULT);
        end
    end

    // State, level and holdoff registers.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (rst) begin
                state_q[c] <= ST_IDLE;
                level_q[c] <= '0;
                hold_q[c]  <= '0;
            end else begin
                state_q[c] <= state_d[c];
                level_q[c] <= level_d[c];
                hold_q[c]  <= hold_d[c];
            end
        end
    end

    // Output flag registers; the acknowledge simply mirrors the sampled request, enabled or not.
    always_ff @(posedge clk) begin
        if (rst) begin
            warn_q   <= '0;
            fault_q  <= '0;
            fevent_q <= '0;
            ack_q    <= '0;
        end else begin
            warn_q   <= warn_d;
            fault_q  <= fault_d;
            fevent_q <= fevent_d;
            ack_q    <= clear_req_i;
        end
    end

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_level
            assign level_o[g*CNT_W +: CNT_W] = level_q[g];
        end
    endgenerate

    assign warn_o        = warn_q;
    assign fault_o       = fault_q;
    assign fault_event_o = fevent_q;
    assign clear_ack_o   = ack_q;
    assign any_fault_o   = |fault_q;

`ifdef CLKS_ALOT_VIOLATION_STICKY_EN
    logic [CHANNELS*SRCS-1:0] sticky_q;

    // Sticky latches see raw violations (mask ignored); only reset or an enabled clear wipes a channel.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (rst) begin
                sticky_q[c*SRCS +: SRCS] <= '0;
            end else if (enable_i && clear_req_i[c]) begin
                sticky_q[c*SRCS +: SRCS] <= '0;
            end else begin
                sticky_q[c*SRCS +: SRCS] <= sticky_q[c*SRCS +: SRCS] | violations_i[c*SRCS +: SRCS];
            end
        end
    end

    assign sticky_src_o = sticky_q;
`else
    assign sticky_src_o = '0;
`endif

endmodule
